sa48_operand_sequencer: RTL and testbench
=========================================

// Module: sa48_operand_sequencer
// PURPOSE
//  Upstream feeder and result collector for the SA48 12-bit-chunk serial adder.
//  Accepts a full 48-bit operand pair plus carry-in over a valid/ready handshake.
//  Slices the operands into four 12-bit chunk pairs, LSB chunk first, and drives them with startChunks.
//  Waits for resultReady, captures the 48-bit sum and carry-out, and presents them over a valid/ready output.
// PARAMETERS
//  CHUNK_W     12  width of one chunk bus (inBusA/inBusB)
//  NUM_CHUNKS  4   chunks per operand; operand width W = CHUNK_W*NUM_CHUNKS (48)
//  TIMEOUT     16  max WAIT cycles for sa_result_ready before abort (>=2)
// PORTS
//  clk              in   1        single clock, rising edge
//  rst              in   1        synchronous, active-high reset
//  in_valid         in   1        operand pair valid
//  in_ready         out  1        sequencer can accept an operand pair
//  in_a             in   W        operand A
//  in_b             in   W        operand B
//  in_ci            in   1        carry-in for this addition
//  sa_bus_a         out  CHUNK_W  chunk of A to SA48 inBusA
//  sa_bus_b         out  CHUNK_W  chunk of B to SA48 inBusB
//  sa_start_chunks  out  1        to SA48 startChunks; high with chunk 0 only
//  sa_ci            out  1        to SA48 ci
//  sa_result_ready  in   1        from SA48 resultReady
//  sa_out_bus       in   W        from SA48 outBus
//  sa_co            in   1        from SA48 co
//  out_valid        out  1        captured result valid
//  out_ready        in   1        consumer accepts result
//  out_sum          out  W        captured sum
//  out_co           out  1        captured carry-out
//  timeout_err      out  1        one-cycle pulse: SA48 never reported a result
// BEHAVIOUR
//  - All outputs are registered. On reset (any state, including mid-operation):
//    - state=IDLE, chunk counter and timer cleared.
//    - in_ready=1; sa_bus_a/b=0, sa_start_chunks=0, sa_ci=0.
//    - out_valid=0, out_sum=0, out_co=0, timeout_err=0.
//  - States: IDLE, SEND, WAIT, HOLD.
//  - IDLE: in_ready=1. Accept on in_valid&&in_ready and latch in_a, in_b, in_ci; next state SEND with cnt=0.
//  - SEND: one cycle per chunk, cnt = 0..NUM_CHUNKS-1, on consecutive cycles with no gaps.
//    - sa_bus_a = a[cnt*CHUNK_W +: CHUNK_W]; sa_bus_b likewise from b.
//    - sa_start_chunks=1 only when cnt==0.
//    - Leave for WAIT with timer=0 after cnt==NUM_CHUNKS-1.
//  - sa_ci = latched ci throughout SEND and WAIT; 0 elsewhere.
//  - sa_bus_a/b = 0 outside SEND.
//  - sa_result_ready is ignored in IDLE, SEND and HOLD.
//  - WAIT: sa_result_ready=1 captures sa_out_bus into out_sum and sa_co into out_co, then goes to HOLD.
//    - out_valid=1 in the next cycle.
//    - Otherwise the timer increments each cycle.
//  - WAIT timeout: the TIMEOUT-th WAIT cycle has no sa_result_ready -> state goes to IDLE.
//    - timeout_err=1 for exactly one cycle, coincident with the first IDLE cycle.
//    - out_valid stays 0 and out_sum/out_co keep their old values.
//  - HOLD: out_valid=1; out_sum and out_co hold stable until out_valid&&out_ready.
//    - After that handshake: IDLE, out_valid=0 next cycle.
//  - in_ready=0 in SEND, WAIT and HOLD. No bypass: a new pair is accepted no earlier than the cycle after the output handshake.
//  - Minimum latency, accept to out_valid: 1 + NUM_CHUNKS + 1 cycles when SA48 answers in the first WAIT cycle.
//  - The sequencer does no arithmetic; out_sum and out_co are passed through unmodified from SA48.
// TESTING
//  1. A=0x123456789ABC, B=0x000000000001, ci=0
//     -> sa_bus_a = 0xABC, 0x789, 0x456, 0x123 on 4 consecutive cycles; start pulses with the first only.
//     -> model answer gives out_sum=0x123456789ABD, out_co=0.
//  2. A=B=0xFFFFFFFFFFFF, ci=1 -> sa_ci=1 through SEND/WAIT; out_sum=0xFFFFFFFFFFFF, out_co=1.
//  3. out_ready low for 5 cycles in HOLD -> out_valid, out_sum, out_co stable; in_ready=0; released on the 6th cycle.
//  4. Model never asserts resultReady -> timeout_err pulses once, TIMEOUT cycles after WAIT entry; in_ready=1; out_valid=0.
//  5. rst asserted at cnt=2 in SEND -> next cycle all outputs at reset values; a new pair is accepted normally.
//  6. Spurious sa_result_ready during SEND -> ignored, no capture.
//     in_valid held high with two pairs -> second is accepted only the cycle after the first output handshake.

Source files
------------

// File: rtl/sa48_operand_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : sa48_operand_sequencer
//  Brief    : Feeds 48-bit operand pairs to the SA48 chunk-serial adder as
//             LSB-first 12-bit chunks and returns its sum over valid/ready.
//  Revision : 1.0  initial release
// ============================================================================
module sa48_operand_sequencer #(
    parameter int CHUNK_W    = 12,
    parameter int NUM_CHUNKS = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [CHUNK_W*NUM_CHUNKS-1:0] in_a,
    input  logic [CHUNK_W*NUM_CHUNKS-1:0] in_b,
    input  logic                          in_ci,
    output logic [CHUNK_W-1:0]            sa_bus_a,
    output logic [CHUNK_W-1:0]            sa_bus_b,
    output logic                          sa_start_chunks,
    output logic                          sa_ci,
    input  logic                          sa_result_ready,
    input  logic [CHUNK_W*NUM_CHUNKS-1:0] sa_out_bus,
    input  logic                          sa_co,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CHUNK_W*NUM_CHUNKS-1:0] out_sum,
    output logic                          out_co,
    output logic                          timeout_err
);

    localparam int c_op_w  = CHUNK_W * NUM_CHUNKS;
    localparam int c_cnt_w = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int c_tmr_w = $clog2(TIMEOUT + 1);

    localparam logic [c_cnt_w-1:0] c_last_chunk = c_cnt_w'(NUM_CHUNKS - 1);
    localparam logic [c_tmr_w-1:0] c_last_wait  = c_tmr_w'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t               r_state_q,     w_state_d;
    logic [c_cnt_w-1:0]   r_cnt_q,       w_cnt_d;
    logic [c_tmr_w-1:0]   r_tmr_q,       w_tmr_d;
    logic [c_op_w-1:0]    r_a_q,         w_a_d;
    logic [c_op_w-1:0]    r_b_q,         w_b_d;
    logic                 r_in_ready_q,  w_in_ready_d;
    logic [CHUNK_W-1:0]   r_bus_a_q,     w_bus_a_d;
    logic [CHUNK_W-1:0]   r_bus_b_q,     w_bus_b_d;
    logic                 r_start_q,     w_start_d;
    logic                 r_sa_ci_q,     w_sa_ci_d;
    logic                 r_out_valid_q, w_out_valid_d;
    logic [c_op_w-1:0]    r_sum_q,       w_sum_d;
    logic                 r_co_q,        w_co_d;
    logic                 r_tmo_q,       w_tmo_d;

    // Every output is a flop, so each branch computes the value the outputs
    // must show in the state being entered. The operand registers are shifted
    // right one chunk per SEND cycle, so the next chunk is always the low slice.
    always_comb begin
        w_state_d     = r_state_q;
        w_cnt_d       = r_cnt_q;
        w_tmr_d       = r_tmr_q;
        w_a_d         = r_a_q;
        w_b_d         = r_b_q;
        w_in_ready_d  = r_in_ready_q;
        w_bus_a_d     = '0;
        w_bus_b_d     = '0;
        w_start_d     = 1'b0;
        w_sa_ci_d     = r_sa_ci_q;
        w_out_valid_d = r_out_valid_q;
        w_sum_d       = r_sum_q;
        w_co_d        = r_co_q;
        w_tmo_d       = 1'b0;

        case (r_state_q)
            S_IDLE: begin
                w_in_ready_d = 1'b1;
                w_sa_ci_d    = 1'b0;
                if (in_valid && r_in_ready_q) begin
                    w_state_d    = S_SEND;
                    w_cnt_d      = '0;
                    w_a_d        = in_a >> CHUNK_W;
                    w_b_d        = in_b >> CHUNK_W;
                    w_bus_a_d    = in_a[CHUNK_W-1:0];
                    w_bus_b_d    = in_b[CHUNK_W-1:0];
                    w_start_d    = 1'b1;
                    w_sa_ci_d    = in_ci;
                    w_in_ready_d = 1'b0;
                end
            end

            S_SEND: begin
                if (r_cnt_q == c_last_chunk) begin
                    w_state_d = S_WAIT;
                    w_tmr_d   = '0;
                end else begin
                    w_cnt_d   = r_cnt_q + c_cnt_w'(1);
                    w_bus_a_d = r_a_q[CHUNK_W-1:0];
                    w_bus_b_d = r_b_q[CHUNK_W-1:0];
                    w_a_d     = r_a_q >> CHUNK_W;
                    w_b_d     = r_b_q >> CHUNK_W;
                end
            end

            S_WAIT: begin
                if (sa_result_ready) begin
                    w_state_d     = S_HOLD;
                    w_sum_d       = sa_out_bus;
                    w_co_d        = sa_co;
                    w_out_valid_d = 1'b1;
                    w_sa_ci_d     = 1'b0;
                end else if (r_tmr_q == c_last_wait) begin
                    // Abort: previous result registers are left untouched.
                    w_state_d    = S_IDLE;
                    w_tmo_d      = 1'b1;
                    w_in_ready_d = 1'b1;
                    w_sa_ci_d    = 1'b0;
                end else begin
                    w_tmr_d = r_tmr_q + c_tmr_w'(1);
                end
            end

            S_HOLD: begin
                if (r_out_valid_q && out_ready) begin
                    w_state_d     = S_IDLE;
                    w_out_valid_d = 1'b0;
                    w_in_ready_d  = 1'b1;
                end
            end

            default: begin
                w_state_d     = S_IDLE;
                w_in_ready_d  = 1'b1;
                w_sa_ci_d     = 1'b0;
                w_out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= S_IDLE;
            r_cnt_q       <= '0;
            r_tmr_q       <= '0;
            r_a_q         <= '0;
            r_b_q         <= '0;
            r_in_ready_q  <= 1'b1;
            r_bus_a_q     <= '0;
            r_bus_b_q     <= '0;
            r_start_q     <= 1'b0;
            r_sa_ci_q     <= 1'b0;
            r_out_valid_q <= 1'b0;
            r_sum_q       <= '0;
            r_co_q        <= 1'b0;
            r_tmo_q       <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_cnt_q       <= w_cnt_d;
            r_tmr_q       <= w_tmr_d;
            r_a_q         <= w_a_d;
            r_b_q         <= w_b_d;
            r_in_ready_q  <= w_in_ready_d;
            r_bus_a_q     <= w_bus_a_d;
            r_bus_b_q     <= w_bus_b_d;
            r_start_q     <= w_start_d;
            r_sa_ci_q     <= w_sa_ci_d;
            r_out_valid_q <= w_out_valid_d;
            r_sum_q       <= w_sum_d;
            r_co_q        <= w_co_d;
            r_tmo_q       <= w_tmo_d;
        end
    end

    assign in_ready        = r_in_ready_q;
    assign sa_bus_a        = r_bus_a_q;
    assign sa_bus_b        = r_bus_b_q;
    assign sa_start_chunks = r_start_q;
    assign sa_ci           = r_sa_ci_q;
    assign out_valid       = r_out_valid_q;
    assign out_sum         = r_sum_q;
    assign out_co          = r_co_q;
    assign timeout_err     = r_tmo_q;

endmodule
`default_nettype wire

// File: tb/tb_sa48_operand_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sa48_operand_sequencer
//  Brief    : Directed scoreboard bench with a behavioural SA48 responder.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sa48_operand_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [47:0] in_a = '0;
    logic [47:0] in_b = '0;
    logic        in_ci = 1'b0;
    logic [11:0] sa_bus_a;
    logic [11:0] sa_bus_b;
    logic        sa_start_chunks;
    logic        sa_ci;
    logic        sa_result_ready = 1'b0;
    logic [47:0] sa_out_bus = '0;
    logic        sa_co = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [47:0] out_sum;
    logic        out_co;
    logic        timeout_err;

    sa48_operand_sequencer #(.CHUNK_W(12), .NUM_CHUNKS(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_ci(in_ci),
        .sa_bus_a(sa_bus_a), .sa_bus_b(sa_bus_b),
        .sa_start_chunks(sa_start_chunks), .sa_ci(sa_ci),
        .sa_result_ready(sa_result_ready), .sa_out_bus(sa_out_bus), .sa_co(sa_co),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_co(out_co), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [47:0] a;
        logic [47:0] b;
        logic        ci;
    } op_t;

    op_t         ops[$];
    logic [48:0] res_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    bit          answer_en = 1'b1;
    bit          spurious  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Scoreboard monitor: pops one expected result per output handshake.
    initial begin : out_mon
        logic [48:0] e;
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (res_q.size() == 0) fail("unexpected_output");
                else begin
                    e = res_q.pop_front();
                    chk("out_sum", 64'(out_sum), 64'(e[47:0]));
                    chk("out_co", 64'(out_co), 64'(e[48]));
                end
            end
        end
    end

    // Chunk monitor: checks each SEND cycle against the queued operand pair.
    initial begin : chunk_mon
        op_t cur;
        int  idx;
        bit  active;
        active = 1'b0;
        idx    = 0;
        forever begin
            @(negedge clk);
            if (sa_start_chunks) begin
                if (active) fail("chunk_restart");
                if (ops.size() == 0) begin
                    fail("unexpected_start");
                    active = 1'b0;
                end else begin
                    cur    = ops.pop_front();
                    idx    = 0;
                    active = 1'b1;
                end
            end else if (active) begin
                idx++;
            end
            if (active) begin
                chk("sa_bus_a", 64'(sa_bus_a), 64'(cur.a[idx*12 +: 12]));
                chk("sa_bus_b", 64'(sa_bus_b), 64'(cur.b[idx*12 +: 12]));
                chk("sa_ci_send", 64'(sa_ci), 64'(cur.ci));
                if (idx == 3) active = 1'b0;
            end
            if (rst) active = 1'b0;
        end
    end

    // Behavioural SA48: gathers four chunks, answers in the first WAIT cycle.
    initial begin : sa_model
        logic [47:0] ma, mb;
        logic        mci;
        logic [48:0] msum;
        int          mcnt;
        bit          pend;
        mcnt = 0;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            sa_result_ready = 1'b0;
            if (rst) begin
                mcnt = 0;
                pend = 1'b0;
            end else begin
                if (pend) begin
                    sa_result_ready = 1'b1;
                    sa_out_bus      = msum[47:0];
                    sa_co           = msum[48];
                    pend            = 1'b0;
                end
                if (sa_start_chunks) begin
                    ma = '0;
                    mb = '0;
                    mci = sa_ci;
                    ma[11:0] = sa_bus_a;
                    mb[11:0] = sa_bus_b;
                    mcnt = 1;
                end else if (mcnt > 0) begin
                    ma[mcnt*12 +: 12] = sa_bus_a;
                    mb[mcnt*12 +: 12] = sa_bus_b;
                    mcnt++;
                end
                if (mcnt == 4) begin
                    msum = {1'b0, ma} + {1'b0, mb} + 49'(mci);
                    pend = answer_en;
                    mcnt = 0;
                end else if (mcnt > 0 && spurious) begin
                    sa_result_ready = 1'b1;
                    sa_out_bus      = 48'hDEADBEEFCAFE;
                    sa_co           = 1'b1;
                end
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_bus_a"}, 64'(sa_bus_a), 64'd0);
        chk({tag, "_bus_b"}, 64'(sa_bus_b), 64'd0);
        chk({tag, "_start"}, 64'(sa_start_chunks), 64'd0);
        chk({tag, "_sa_ci"}, 64'(sa_ci), 64'd0);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_sum"}, 64'(out_sum), 64'd0);
        chk({tag, "_out_co"}, 64'(out_co), 64'd0);
        chk({tag, "_timeout_err"}, 64'(timeout_err), 64'd0);
    endtask

    // Returns just after the accepting edge (first SEND cycle).
    task automatic send(input logic [47:0] a, input logic [47:0] b, input logic ci,
                        input bit has_res, input logic [48:0] exp);
        int n;
        op_t o;
        o.a = a; o.b = b; o.ci = ci;
        ops.push_back(o);
        if (has_res) res_q.push_back(exp);
        @(posedge clk); #1;
        in_valid = 1'b1; in_a = a; in_b = b; in_ci = ci;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) fail("accept_timeout");
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out_valid(output int at);
        int n;
        @(negedge clk);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) fail("out_valid_timeout");
        at = cyc;
    endtask

    initial begin : stim
        int t0, t1, hs, acc, pulses, pulse_at;
        op_t o;

        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: basic carry ripple into chunk 0, latency check
        send(48'h123456789ABC, 48'h000000000001, 1'b0, 1'b1, {1'b0, 48'h123456789ABD});
        t0 = cyc;
        wait_out_valid(t1);
        chk("latency", 64'(t1 - t0), 64'd5);

        // 2: all-ones with carry-in, sa_ci through WAIT
        send(48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF, 1'b1, 1'b1, {1'b1, 48'hFFFFFFFFFFFF});
        repeat (5) @(negedge clk);
        chk("sa_ci_wait", 64'(sa_ci), 64'd1);
        wait_out_valid(t1);
        chk("sa_ci_hold", 64'(sa_ci), 64'd0);

        // 3: consumer stalls five cycles in HOLD
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(48'h800000000000, 48'h800000000000, 1'b0, 1'b1, {1'b1, 48'h000000000000});
        wait_out_valid(t1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_sum", 64'(out_sum), 64'd0);
            chk("hold_co", 64'(out_co), 64'd1);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_hs_valid", 64'(out_valid), 64'd0);
        chk("post_hs_in_ready", 64'(in_ready), 64'd1);

        // 4: SA48 silent -> single timeout pulse 16 cycles after WAIT entry
        answer_en = 1'b0;
        send(48'h111111111111, 48'h222222222222, 1'b0, 1'b0, '0);
        pulses = 0;
        pulse_at = 0;
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            if (timeout_err) begin
                pulses++;
                pulse_at = i;
                chk("tmo_in_ready", 64'(in_ready), 64'd1);
                chk("tmo_out_valid", 64'(out_valid), 64'd0);
                chk("tmo_sum_kept", 64'(out_sum), 64'd0);
                chk("tmo_co_kept", 64'(out_co), 64'd1);
            end
        end
        chk("tmo_pulses", 64'(pulses), 64'd1);
        chk("tmo_cycle", 64'(pulse_at), 64'd21);
        answer_en = 1'b1;

        // 5: reset while cnt==2 in SEND
        send(48'h0F0F0F0F0F0F, 48'h010101010101, 1'b1, 1'b0, '0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("midrst");
        while (ops.size() > 0) o = ops.pop_front();
        send(48'h000000000FFF, 48'h000000000001, 1'b0, 1'b1, {1'b0, 48'h000000001000});
        wait_out_valid(t1);

        // 6: spurious result_ready during SEND; back-to-back pairs, no bypass
        spurious = 1'b1;
        o.a = 48'h7FFFFFFFFFFF; o.b = 48'h000000000001; o.ci = 1'b0;
        ops.push_back(o);
        res_q.push_back({1'b0, 48'h800000000000});
        @(posedge clk); #1;
        in_valid = 1'b1; in_a = o.a; in_b = o.b; in_ci = o.ci;
        @(negedge clk);
        for (int n = 0; n < 100 && !in_ready; n++) @(negedge clk);
        if (!in_ready) fail("accept1_timeout");
        @(posedge clk); #1;
        o.a = 48'hAAAAAAAAAAAA; o.b = 48'h555555555555; o.ci = 1'b1;
        ops.push_back(o);
        res_q.push_back({1'b1, 48'h000000000000});
        in_a = o.a; in_b = o.b; in_ci = o.ci;
        hs = -100;
        acc = -1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (out_valid && out_ready) hs = cyc;
            if (in_ready) begin
                acc = cyc;
                break;
            end
        end
        chk("second_accept_gap", 64'(acc - hs), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        spurious = 1'b0;
        wait_out_valid(t1);

        repeat (4) @(negedge clk);
        chk("sb_results_drained", 64'(res_q.size()), 64'd0);
        chk("sb_ops_drained", 64'(ops.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
